// File: rtl/fp_mul_booth_seq.sv
`default_nettype none
// ============================================================================
// Module  : fp_mul_booth_seq
// Brief   : Sequential radix-4 Booth multiplier producing the exact 48-bit
//           significand product {1,frc_X} x {1,frc_Y} for binary32 multiply.
// Revision: 1.0 - initial release
// ============================================================================
module fp_mul_booth_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [22:0] frc_X,
    input  logic [22:0] frc_Y,
    input  logic        x_sub,
    input  logic        y_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] frc_Z_full,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_DIGIT = 4'd12;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [23:0] r_a;
    logic [23:0] r_b;
    logic [49:0] r_acc;
    logic        r_flush;
    logic [47:0] r_z;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_in_ready;

    logic [26:0] w_b_ext;
    logic [2:0]  w_trip;
    logic [49:0] w_a_ext;
    logic [49:0] w_pp;
    logic [49:0] w_term;
    logic [49:0] w_acc_next;

    // B[-1]=0 at the bottom, two zero bits on top so the last digit is never negative
    assign w_b_ext = {2'b00, r_b, 1'b0};
    assign w_trip  = w_b_ext[{r_cnt, 1'b0} +: 3];
    assign w_a_ext = {26'd0, r_a};

    always_comb begin
        w_pp = 50'd0;
        case (w_trip)
            3'b001, 3'b010: w_pp = w_a_ext;
            3'b011:         w_pp = w_a_ext << 1;
            3'b100:         w_pp = 50'd0 - (w_a_ext << 1);
            3'b101, 3'b110: w_pp = 50'd0 - w_a_ext;
            default:        w_pp = 50'd0;
        endcase
    end

    // Explicit weight 4^i; the two's-complement wrap modulo 2^50 keeps it exact
    assign w_term     = w_pp << {r_cnt, 1'b0};
    assign w_acc_next = r_acc + w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_a         <= 24'd0;
            r_b         <= 24'd0;
            r_acc       <= 50'd0;
            r_flush     <= 1'b0;
            r_z         <= 48'h0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_flush) begin
                        // Flushed operand: spend one cycle, then present zero
                        r_flush     <= 1'b0;
                        r_z         <= 48'h0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (in_valid) begin
                        r_a        <= {1'b1, frc_X};
                        r_b        <= {1'b1, frc_Y};
                        r_acc      <= 50'd0;
                        r_cnt      <= 4'd0;
                        r_in_ready <= 1'b0;
                        if (x_sub || y_sub) begin
                            r_flush <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_DIGIT) begin
                        r_z         <= w_acc_next[47:0];
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_flush     <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign frc_Z_full = r_z;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_booth_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_mul_booth_seq
// Brief   : Randomized self-checking bench for fp_mul_booth_seq against a
//           plain-arithmetic product model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_mul_booth_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] frc_X;
    logic [22:0] frc_Y;
    logic        x_sub;
    logic        y_sub;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] frc_Z_full;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fp_mul_booth_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frc_X      (frc_X),
        .frc_Y      (frc_Y),
        .x_sub      (x_sub),
        .y_sub      (y_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frc_Z_full (frc_Z_full),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] model(input logic [22:0] x, input logic [22:0] y,
                                          input logic xs, input logic ys);
        logic [47:0] a;
        logic [47:0] b;
        a = {24'd0, 1'b1, x};
        b = {24'd0, 1'b1, y};
        if (xs || ys) return 48'h0;
        return a * b;
    endfunction

    // Present one pair for exactly one accepting edge; returns at the negedge after accept
    task automatic issue(input logic [22:0] x, input logic [22:0] y,
                         input logic xs, input logic ys);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL issue_ready_timeout in_ready=%b required=1", in_ready);
        end
        frc_X = x; frc_Y = y; x_sub = xs; y_sub = ys; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit busy_seen);
        lat = 0;
        busy_seen = busy;
        while (!out_valid && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (busy) busy_seen = 1'b1;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        frc_X = '0; frc_Y = '0; x_sub = 1'b0; y_sub = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (frc_Z_full !== 48'h0) begin bad++; $display("FAIL reset_product got=%h exp=0", frc_Z_full); end
    endtask

    task automatic test_directed();
        logic [22:0] xs [3];
        int lat;
        bit bs;
        logic [47:0] exp_z;
        xs[0] = 23'h000000; xs[1] = 23'h400000; xs[2] = 23'h7FFFFF;
        for (int i = 0; i < 3; i++) begin
            exp_z = model(xs[i], xs[i], 1'b0, 1'b0);
            issue(xs[i], xs[i], 1'b0, 1'b0);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL directed_busy[%0d] got=%b exp=1", i, busy); end
            wait_valid(lat, bs);
            total++; if (lat != 13) begin bad++; $display("FAIL directed_latency[%0d] got=%0d exp=13", i, lat); end
            total++; if (frc_Z_full !== exp_z) begin bad++; $display("FAIL directed_product[%0d] got=%h exp=%h", i, frc_Z_full, exp_z); end
            consume();
        end
    endtask

    task automatic test_flush();
        int lat;
        bit bs;
        for (int i = 0; i < 2; i++) begin
            issue(23'($urandom), 23'($urandom), (i == 0), (i == 1));
            wait_valid(lat, bs);
            total++; if (lat != 1) begin bad++; $display("FAIL flush_latency[%0d] got=%0d exp=1", i, lat); end
            total++; if (frc_Z_full !== 48'h0) begin bad++; $display("FAIL flush_product[%0d] got=%h exp=0", i, frc_Z_full); end
            total++; if (bs !== 1'b0) begin bad++; $display("FAIL flush_busy[%0d] got=%b exp=0", i, bs); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [22:0] x1, y1, nx, ny;
        logic [47:0] e1, e2;
        int lat;
        bit bs;
        x1 = 23'($urandom); y1 = 23'($urandom);
        nx = 23'($urandom); ny = 23'($urandom);
        e1 = model(x1, y1, 1'b0, 1'b0);
        e2 = model(nx, ny, 1'b0, 1'b0);
        issue(x1, y1, 1'b0, 1'b0);
        wait_valid(lat, bs);
        total++; if (frc_Z_full !== e1) begin bad++; $display("FAIL bp_first_product got=%h exp=%h", frc_Z_full, e1); end
        for (int k = 0; k < 5; k++) begin
            frc_X = 23'($urandom); frc_Y = 23'($urandom); in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            total++; if (frc_Z_full !== e1 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b exp=%h/1", k, frc_Z_full, out_valid, e1); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); end
        end
        frc_X = nx; frc_Y = ny; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_cycle got=%b/%b exp=1/0", in_ready, out_valid); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat, bs);
        total++; if (lat != 13) begin bad++; $display("FAIL bp_second_latency got=%0d exp=13", lat); end
        total++; if (frc_Z_full !== e2) begin bad++; $display("FAIL bp_second_product got=%h exp=%h", frc_Z_full, e2); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit pulsed;
        issue(23'($urandom), 23'($urandom), 1'b0, 1'b0);
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_flags got=%b/%b exp=0/0", out_valid, busy); end
        total++; if (in_ready !== 1'b1 || frc_Z_full !== 48'h0) begin bad++; $display("FAIL midreset_ready_product got=%b/%h exp=1/0", in_ready, frc_Z_full); end
        @(negedge clk);
        rst_n = 1'b1;
        pulsed = 1'b0;
        repeat (20) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) pulsed = 1'b1;
        end
        total++; if (pulsed !== 1'b0) begin bad++; $display("FAIL midreset_no_pulse got=%b exp=0", pulsed); end
    endtask

    task automatic test_random();
        logic [22:0] x, y;
        logic xs, ys;
        logic [47:0] e;
        int lat;
        bit bs;
        for (int n = 0; n < 1001; n++) begin
            x = 23'($urandom); y = 23'($urandom);
            xs = ($urandom_range(0, 15) == 0);
            ys = ($urandom_range(0, 15) == 0);
            if (n == 0) begin xs = 1'b0; ys = 1'b0; end
            e = model(x, y, xs, ys);
            issue(x, y, xs, ys);
            wait_valid(lat, bs);
            total++; if (lat != ((xs || ys) ? 1 : 13)) begin bad++; $display("FAIL rand_latency[%0d] got=%0d x=%h y=%h sub=%b%b", n, lat, x, y, xs, ys); end
            total++; if (frc_Z_full !== e) begin bad++; $display("FAIL rand_product[%0d] got=%h exp=%h", n, frc_Z_full, e); end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
